// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end and phase sequencer for the multi-cycle CPU.
// Owns the program counter, addresses the instruction ROM, latches the raw
// instruction and drives one-hot FETCH/DECODE/EXECUTE phase strobes.
//
// Handshake: exec_stall is sampled only in EXECUTE and holds that state
// while high. redirect_valid/redirect_target are sampled only on the final
// (non-stalled) EXECUTE cycle; at any other time they are ignored.
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 18,
  parameter logic [3:0]  HALT_OP = 4'b1111,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] raw_instruction,
  output logic               fetch_clk,
  output logic               dec_clk,
  output logic               alu_clk,
  input  logic               exec_stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0] op_code;
  logic       retire;

  assign op_code = raw_instruction[INSTR_W-1 -: 4];
  // An instruction ends on a non-stalled EXECUTE cycle.
  assign retire  = (state_q == S_EXECUTE) && !exec_stall;

  // Strobes and status are a pure decode of the state register.
  assign fetch_clk = (state_q == S_FETCH);
  assign dec_clk   = (state_q == S_DECODE);
  assign alu_clk   = (state_q == S_EXECUTE);
  assign halted    = (state_q == S_HALT);
  assign rom_addr  = pc;
  assign state_dbg = state_q;

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the fetch/decode/execute sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (!exec_stall) begin
          state_d = (op_code == HALT_OP) ? S_HALT : S_FETCH;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the instruction in FETCH; advance pc and the retired
  // count when an instruction ends (a halt instruction also retires).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc              <= '0;
      raw_instruction <= '0;
      instr_count     <= '0;
    end else begin
      if (state_q == S_FETCH) begin
        raw_instruction <= rom_data;
      end
      if (retire) begin
        pc <= redirect_valid ? redirect_target : pc + ADDR_W'(1);
        if (instr_count != {CNT_W{1'b1}}) begin
          instr_count <= instr_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, straight-line sequencing,
// redirect, stall with pc wrap, halt, async reset and counter saturation.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  rom_addr;
  logic [17:0] rom_data;
  logic [17:0] raw_instruction;
  logic        fetch_clk;
  logic        dec_clk;
  logic        alu_clk;
  logic        exec_stall;
  logic        redirect_valid;
  logic [3:0]  redirect_target;
  logic [3:0]  pc;
  logic        halted;
  logic [7:0]  instr_count;
  logic [2:0]  state_dbg;

  logic [17:0] rom [16];
  int checks;
  int failures;

  assign rom_data = rom[rom_addr];

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .raw_instruction (raw_instruction),
    .fetch_clk       (fetch_clk),
    .dec_clk         (dec_clk),
    .alu_clk         (alu_clk),
    .exec_stall      (exec_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .halted          (halted),
    .instr_count     (instr_count),
    .state_dbg       (state_dbg)
  );

  // Clock: 10 time-unit period, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample and drive 1 unit after the posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset 3 cycles, release; the DUT is then in its IDLE cycle.
  task automatic do_reset();
    rst = 1'b0;
    exec_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 4'h0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fetch_clk, dec_clk, alu_clk, halted} !== 4'b0000 || pc !== 4'h0 ||
        raw_instruction !== 18'h0 || instr_count !== 8'h0) begin
      failures++;
      $display("FAIL reset_state got strobes=%b halted=%b pc=%h raw=%h cnt=%0d exp 000 0 0 0 0",
               {fetch_clk, dec_clk, alu_clk}, halted, pc, raw_instruction, instr_count);
    end
    tick();
    checks++;
    if ({fetch_clk, dec_clk, alu_clk} !== 3'b100 || rom_addr !== 4'h0) begin
      failures++;
      $display("FAIL reset_first_fetch got strobes=%b rom_addr=%h exp 100 0",
               {fetch_clk, dec_clk, alu_clk}, rom_addr);
    end
  endtask

  task automatic test_straight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({fetch_clk, dec_clk, alu_clk} !== 3'b100 || rom_addr !== 4'(i)) begin
        failures++;
        $display("FAIL straight_fetch%0d got strobes=%b rom_addr=%h exp 100 %h",
                 i, {fetch_clk, dec_clk, alu_clk}, rom_addr, 4'(i));
      end
      tick();
      checks++;
      if ({fetch_clk, dec_clk, alu_clk} !== 3'b010 || raw_instruction !== rom[i]) begin
        failures++;
        $display("FAIL straight_decode%0d got strobes=%b raw=%h exp 010 %h",
                 i, {fetch_clk, dec_clk, alu_clk}, raw_instruction, rom[i]);
      end
      tick();
      checks++;
      if ({fetch_clk, dec_clk, alu_clk} !== 3'b001 || instr_count !== 8'(i)) begin
        failures++;
        $display("FAIL straight_exec%0d got strobes=%b cnt=%0d exp 001 %0d",
                 i, {fetch_clk, dec_clk, alu_clk}, instr_count, i);
      end
    end
    tick();
    checks++;
    if (instr_count !== 8'd3 || pc !== 4'h3 || fetch_clk !== 1'b1) begin
      failures++;
      $display("FAIL straight_end got cnt=%0d pc=%h fetch=%b exp 3 3 1",
               instr_count, pc, fetch_clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();                       // FETCH pc=0
    tick();                       // DECODE: redirect pulse here is ignored
    redirect_valid = 1'b1;
    redirect_target = 4'h5;
    tick();                       // EXECUTE
    redirect_valid = 1'b0;
    tick();                       // FETCH pc=1
    checks++;
    if (pc !== 4'h1) begin
      failures++;
      $display("FAIL redirect_decode_ignored got pc=%h exp 1", pc);
    end
    repeat (3) tick();            // FETCH pc=2
    tick();                       // DECODE
    tick();                       // EXECUTE
    redirect_valid = 1'b1;
    redirect_target = 4'hA;
    tick();                       // FETCH pc=A
    redirect_valid = 1'b0;
    checks++;
    if (rom_addr !== 4'hA || fetch_clk !== 1'b1 || instr_count !== 8'd3) begin
      failures++;
      $display("FAIL redirect_target got rom_addr=%h fetch=%b cnt=%0d exp a 1 3",
               rom_addr, fetch_clk, instr_count);
    end
    tick();
    checks++;
    if (raw_instruction !== 18'h0ABCD) begin
      failures++;
      $display("FAIL redirect_raw got %h exp 0abcd", raw_instruction);
    end
  endtask

  task automatic test_stall_wrap();
    int alu_high;
    do_reset();
    tick();                       // FETCH pc=0
    tick();                       // DECODE
    tick();                       // EXECUTE: redirect to 15
    redirect_valid = 1'b1;
    redirect_target = 4'hF;
    tick();                       // FETCH pc=F
    redirect_valid = 1'b0;
    tick();                       // DECODE
    tick();                       // EXECUTE cycle 1
    exec_stall = 1'b1;
    redirect_valid = 1'b1;        // ignored while stalled
    redirect_target = 4'h7;
    alu_high = 0;
    for (int i = 0; i < 5; i++) begin
      if (alu_clk === 1'b1) alu_high++;
      checks++;
      if (pc !== 4'hF || instr_count !== 8'd1) begin
        failures++;
        $display("FAIL stall_hold%0d got pc=%h cnt=%0d exp f 1", i, pc, instr_count);
      end
      if (i < 4) tick();
    end
    exec_stall = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (alu_high !== 5) begin
      failures++;
      $display("FAIL stall_alu_cycles got %0d exp 5", alu_high);
    end
    tick();                       // FETCH after wrap
    checks++;
    if (pc !== 4'h0 || fetch_clk !== 1'b1 || instr_count !== 8'd2) begin
      failures++;
      $display("FAIL stall_wrap got pc=%h fetch=%b cnt=%0d exp 0 1 2", pc, fetch_clk, instr_count);
    end
    tick();
    checks++;
    if (raw_instruction !== 18'h00123) begin
      failures++;
      $display("FAIL stall_wrap_raw got %h exp 00123", raw_instruction);
    end
  endtask

  task automatic test_halt(input logic use_redirect);
    logic [3:0] exp_pc;
    exp_pc = use_redirect ? 4'h9 : 4'h4;
    do_reset();
    tick();                       // FETCH pc=0
    for (int i = 0; i < 4; i++) begin
      tick();                     // DECODE
      tick();                     // EXECUTE
      if (i == 3 && use_redirect) begin
        redirect_valid = 1'b1;
        redirect_target = 4'h9;
      end
      tick();
      redirect_valid = 1'b0;
    end
    checks++;
    if (halted !== 1'b1 || pc !== exp_pc || instr_count !== 8'd4) begin
      failures++;
      $display("FAIL halt_entry redir=%b got halted=%b pc=%h cnt=%0d exp 1 %h 4",
               use_redirect, halted, pc, instr_count, exp_pc);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({fetch_clk, dec_clk, alu_clk} !== 3'b000 || halted !== 1'b1 || pc !== exp_pc ||
          instr_count !== 8'd4) begin
        failures++;
        $display("FAIL halt_frozen%0d got strobes=%b halted=%b pc=%h cnt=%0d exp 000 1 %h 4",
                 i, {fetch_clk, dec_clk, alu_clk}, halted, pc, instr_count, exp_pc);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) tick();            // FETCH pc=1 (one retired)
    tick();                       // DECODE
    tick();                       // EXECUTE
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({fetch_clk, dec_clk, alu_clk} !== 3'b000 || pc !== 4'h0 ||
        raw_instruction !== 18'h0 || instr_count !== 8'h0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got strobes=%b pc=%h raw=%h cnt=%0d halted=%b exp 000 0 0 0 0",
               {fetch_clk, dec_clk, alu_clk}, pc, raw_instruction, instr_count, halted);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (fetch_clk !== 1'b1 || rom_addr !== 4'h0 || instr_count !== 8'h0) begin
      failures++;
      $display("FAIL async_restart got fetch=%b rom_addr=%h cnt=%0d exp 1 0 0",
               fetch_clk, rom_addr, instr_count);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    rom[3] = 18'h00333;           // no halt in the ROM for this run
    do_reset();
    tick();
    for (int n = 0; n < 260; n++) begin
      repeat (3) tick();
      exp_cnt = (n + 1 > 255) ? 255 : n + 1;
      if (n >= 253) begin
        checks++;
        if (instr_count !== 8'(exp_cnt) || pc !== 4'((n + 1) % 16)) begin
          failures++;
          $display("FAIL saturate%0d got cnt=%0d pc=%h exp %0d %h",
                   n, instr_count, pc, exp_cnt, 4'((n + 1) % 16));
        end
      end
    end
    rom[3] = 18'h3C000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    exec_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 18'h01000 + 18'(i);
    rom[0]  = 18'h00123;
    rom[1]  = 18'h04567;
    rom[2]  = 18'h0789A;
    rom[3]  = 18'h3C000;          // op_code 4'b1111
    rom[10] = 18'h0ABCD;
    rom[15] = 18'h01F0F;

    test_reset();
    test_straight();
    test_redirect();
    test_stall_wrap();
    test_halt(1'b0);
    test_halt(1'b1);
    test_async_reset();
    test_saturate();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
